// File: rtl/ex_excp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ex_excp_ctrl
//  Purpose  : Commit-stage exception/interrupt sequencer. Accepts one
//             committing instruction per handshake and picks the winner among
//             synchronous exceptions, the external IRQ and ERET. It then waits
//             for the LSU to drain and issues a one-cycle special-register
//             save/restore together with a pipeline flush and redirect target.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             cmt_*_i / cmt_ready_o     - commit handshake and instruction info
//             irq_async_i               - level IRQ request, sampled at fire
//             msr_*_i                   - current PSR.IRE, EVECT and EPC
//             lsu_idle_i                - LSU / store buffer empty
//             msr_*_o                   - PSR/EPSR/EPC/ELSA update strobes, data
//             flush_o, flush_tgt_o      - flush pulse and redirect PC
//             excp_busy_o               - sequence in progress
//  Revision : 1.0 - initial release
// ============================================================================
module ex_excp_ctrl #(
   parameter int          CONFIG_DW     = 64,
   parameter logic [11:0] VECT_EITM     = 12'h000,
   parameter logic [11:0] VECT_EIPF     = 12'h100,
   parameter logic [11:0] VECT_EINSN    = 12'h200,
   parameter logic [11:0] VECT_ESYSCALL = 12'h300,
   parameter logic [11:0] VECT_EALIGN   = 12'h400,
   parameter logic [11:0] VECT_EDTM     = 12'h500,
   parameter logic [11:0] VECT_EDPF     = 12'h600,
   parameter logic [11:0] VECT_EIRQ     = 12'h700
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmt_valid_i,
   output logic                 cmt_ready_o,
   input  logic [CONFIG_DW-1:0] cmt_pc_i,
   input  logic [6:0]           cmt_exc_i,
   input  logic [CONFIG_DW-1:0] cmt_lsa_i,
   input  logic                 cmt_eret_i,
   input  logic                 irq_async_i,
   input  logic                 msr_psr_ire_i,
   input  logic [CONFIG_DW-1:0] msr_evect_i,
   input  logic [CONFIG_DW-1:0] msr_epc_i,
   input  logic                 lsu_idle_i,
   output logic                 msr_psr_save_o,
   output logic                 msr_psr_restore_o,
   output logic                 msr_epc_we_o,
   output logic [CONFIG_DW-1:0] msr_epc_nxt_o,
   output logic                 msr_elsa_we_o,
   output logic [CONFIG_DW-1:0] msr_elsa_nxt_o,
   output logic                 flush_o,
   output logic [CONFIG_DW-1:0] flush_tgt_o,
   output logic                 excp_busy_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRAIN   = 2'd1,
      ENTER   = 2'd2,
      RESTORE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 ret_q;
   logic                 elsa_we_q;
   logic [CONFIG_DW-1:0] vec_q;
   logic [CONFIG_DW-1:0] epc_q;
   logic [CONFIG_DW-1:0] elsa_q;

   logic                 w_fire;
   logic                 w_sync;
   logic                 w_irq;
   logic                 w_ret;
   logic                 w_start;
   logic [11:0]          w_off;
   logic [CONFIG_DW-1:0] w_epc;
   logic [CONFIG_DW-1:0] w_elsa;
   logic                 w_elsa_we;

   assign w_fire  = cmt_valid_i & (state_q == IDLE);
   assign w_sync  = |cmt_exc_i;
   assign w_irq   = irq_async_i & msr_psr_ire_i & ~w_sync & ~cmt_eret_i;
   // ERET only restores when no exception bit is set; IRQ is already
   // excluded by ERET so the two never coincide.
   assign w_ret   = cmt_eret_i & ~w_sync;
   assign w_start = w_fire & (w_sync | w_irq | w_ret);

   // Lowest set exception bit wins; the IRQ vector is the fallback.
   always_comb begin
      w_off     = VECT_EIRQ;
      w_epc     = cmt_pc_i;
      w_elsa    = '0;
      w_elsa_we = 1'b0;
      if (cmt_exc_i[0]) begin
         w_off     = VECT_EITM;
         w_elsa    = cmt_pc_i;
         w_elsa_we = 1'b1;
      end else if (cmt_exc_i[1]) begin
         w_off     = VECT_EIPF;
         w_elsa    = cmt_pc_i;
         w_elsa_we = 1'b1;
      end else if (cmt_exc_i[2]) begin
         w_off     = VECT_EINSN;
      end else if (cmt_exc_i[3]) begin
         w_off     = VECT_ESYSCALL;
         w_epc     = cmt_pc_i + CONFIG_DW'(4);  // resume after the syscall
      end else if (cmt_exc_i[4]) begin
         w_off     = VECT_EALIGN;
         w_elsa    = cmt_lsa_i;
         w_elsa_we = 1'b1;
      end else if (cmt_exc_i[5]) begin
         w_off     = VECT_EDTM;
         w_elsa    = cmt_lsa_i;
         w_elsa_we = 1'b1;
      end else if (cmt_exc_i[6]) begin
         w_off     = VECT_EDPF;
         w_elsa    = cmt_lsa_i;
         w_elsa_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ret_q     <= 1'b0;
         elsa_we_q <= 1'b0;
         vec_q     <= '0;
         epc_q     <= '0;
         elsa_q    <= '0;
      end else begin
         state_q <= state_d;
         if (w_start) begin
            ret_q     <= w_ret;
            elsa_we_q <= w_elsa_we & ~w_ret;
            vec_q     <= msr_evect_i + {{(CONFIG_DW-12){1'b0}}, w_off};
            epc_q     <= w_epc;
            elsa_q    <= w_elsa_we ? w_elsa : '0;
         end
      end
   end

   // Outputs decode registered state only; no cmt_* input reaches a strobe.
   always_comb begin
      state_d           = state_q;
      cmt_ready_o       = 1'b0;
      excp_busy_o       = 1'b1;
      msr_psr_save_o    = 1'b0;
      msr_psr_restore_o = 1'b0;
      msr_epc_we_o      = 1'b0;
      msr_epc_nxt_o     = '0;
      msr_elsa_we_o     = 1'b0;
      msr_elsa_nxt_o    = '0;
      flush_o           = 1'b0;
      flush_tgt_o       = '0;
      case (state_q)
         IDLE: begin
            cmt_ready_o = 1'b1;
            excp_busy_o = 1'b0;
            if (w_start) state_d = DRAIN;
         end
         DRAIN: begin
            if (lsu_idle_i) state_d = ret_q ? RESTORE : ENTER;
         end
         ENTER: begin
            msr_psr_save_o = 1'b1;
            msr_epc_we_o   = 1'b1;
            msr_epc_nxt_o  = epc_q;
            msr_elsa_we_o  = elsa_we_q;
            msr_elsa_nxt_o = elsa_q;
            flush_o        = 1'b1;
            flush_tgt_o    = vec_q;
            state_d        = IDLE;
         end
         RESTORE: begin
            msr_psr_restore_o = 1'b1;
            flush_o           = 1'b1;
            flush_tgt_o       = msr_epc_i;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ex_excp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_excp_ctrl
//  Purpose  : Self-checking bench for ex_excp_ctrl. A transaction-level model
//             predicts every output on every cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_excp_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmt_valid = 1'b0;
   logic        cmt_ready;
   logic [63:0] cmt_pc = '0;
   logic [6:0]  cmt_exc = '0;
   logic [63:0] cmt_lsa = '0;
   logic        cmt_eret = 1'b0;
   logic        irq_async = 1'b0;
   logic        msr_psr_ire = 1'b0;
   logic [63:0] msr_evect = 64'h1000;
   logic [63:0] msr_epc = '0;
   logic        lsu_idle = 1'b1;
   logic        psr_save, psr_restore, epc_we, elsa_we, flush, busy;
   logic [63:0] epc_nxt, elsa_nxt, flush_tgt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_excp_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .cmt_valid_i       (cmt_valid),
      .cmt_ready_o       (cmt_ready),
      .cmt_pc_i          (cmt_pc),
      .cmt_exc_i         (cmt_exc),
      .cmt_lsa_i         (cmt_lsa),
      .cmt_eret_i        (cmt_eret),
      .irq_async_i       (irq_async),
      .msr_psr_ire_i     (msr_psr_ire),
      .msr_evect_i       (msr_evect),
      .msr_epc_i         (msr_epc),
      .lsu_idle_i        (lsu_idle),
      .msr_psr_save_o    (psr_save),
      .msr_psr_restore_o (psr_restore),
      .msr_epc_we_o      (epc_we),
      .msr_epc_nxt_o     (epc_nxt),
      .msr_elsa_we_o     (elsa_we),
      .msr_elsa_nxt_o    (elsa_nxt),
      .flush_o           (flush),
      .flush_tgt_o       (flush_tgt),
      .excp_busy_o       (busy)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transaction model: a started sequence is pending until its flush
   // cycle; the flush cycle follows the first post-fire cycle that sees
   // lsu_idle. Payload is derived directly from the priority rules.
   // ---------------------------------------------------------------------
   logic        m_pend = 1'b0;
   logic        m_drn  = 1'b0;
   logic        m_ret  = 1'b0;
   logic        m_ewe  = 1'b0;
   logic [63:0] m_tgt  = '0;
   logic [63:0] m_epc  = '0;
   logic [63:0] m_elsa = '0;
   int          lo;

   always @(posedge clk) begin
      if (rst) begin
         m_pend <= 1'b0;
         m_drn  <= 1'b0;
      end else if (!m_pend) begin
         if (cmt_valid) begin
            lo = -1;
            for (int i = 6; i >= 0; i--) if (cmt_exc[i]) lo = i;
            m_drn <= 1'b0;
            if (lo >= 0) begin
               m_pend <= 1'b1;
               m_ret  <= 1'b0;
               m_tgt  <= msr_evect + 64'(lo * 256);
               m_epc  <= (lo == 3) ? cmt_pc + 64'd4 : cmt_pc;
               m_ewe  <= (lo != 2) && (lo != 3);
               m_elsa <= (lo >= 4) ? cmt_lsa : cmt_pc;
            end else if (cmt_eret) begin
               m_pend <= 1'b1;
               m_ret  <= 1'b1;
            end else if (irq_async && msr_psr_ire) begin
               m_pend <= 1'b1;
               m_ret  <= 1'b0;
               m_tgt  <= msr_evect + 64'h700;
               m_epc  <= cmt_pc;
               m_ewe  <= 1'b0;
            end
         end
      end else if (!m_drn) begin
         if (lsu_idle) m_drn <= 1'b1;
      end else begin
         m_pend <= 1'b0;
      end
   end

   logic e_flush, e_save, e_rest, e_ewe;
   always @(negedge clk) begin
      e_flush = m_pend && m_drn;
      e_save  = e_flush && !m_ret;
      e_rest  = e_flush && m_ret;
      e_ewe   = e_save && m_ewe;
      chk1 ("cmt_ready",   cmt_ready,   !m_pend);
      chk1 ("excp_busy",   busy,        m_pend);
      chk1 ("flush",       flush,       e_flush);
      chk1 ("psr_save",    psr_save,    e_save);
      chk1 ("psr_restore", psr_restore, e_rest);
      chk1 ("epc_we",      epc_we,      e_save);
      chk64("epc_nxt",     epc_nxt,     e_save ? m_epc : 64'h0);
      chk1 ("elsa_we",     elsa_we,     e_ewe);
      chk64("elsa_nxt",    elsa_nxt,    e_ewe ? m_elsa : 64'h0);
      chk64("flush_tgt",   flush_tgt,   !e_flush ? 64'h0 : (m_ret ? msr_epc : m_tgt));
   end

   // ---------------------------------------------------------------------
   // Directed stimulus; inputs change 1 time unit after each rising edge.
   // ---------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fire(input logic [63:0] pc, input logic [6:0] exc,
                       input logic [63:0] lsa, input logic eret);
      cmt_valid = 1'b1;
      cmt_pc    = pc;
      cmt_exc   = exc;
      cmt_lsa   = lsa;
      cmt_eret  = eret;
      step();
      cmt_valid = 1'b0;
      cmt_exc   = '0;
      cmt_eret  = 1'b0;
   endtask

   initial begin
      step();
      step();
      #1;
      chk1("rst_ready", cmt_ready, 1'b1);
      chk1("rst_flush", flush, 1'b0);
      chk1("rst_busy",  busy,  1'b0);
      rst = 1'b0;

      // EINSN, LSU idle: ENTER two cycles after fire
      step();
      fire(64'h2000, 7'b0000100, 64'h9999, 1'b0);
      step(); #1;
      chk1 ("t1_flush",   flush,    1'b1);
      chk1 ("t1_save",    psr_save, 1'b1);
      chk64("t1_epc",     epc_nxt,  64'h2000);
      chk1 ("t1_elsa_we", elsa_we,  1'b0);
      chk64("t1_tgt",     flush_tgt, 64'h1200);
      step(); #1;
      chk1("t1_ready_after", cmt_ready, 1'b1);

      // ESYSCALL with three cycles of LSU busy: flush 5 cycles after fire
      lsu_idle = 1'b0;
      fire(64'h3000, 7'b0001000, 64'h0, 1'b0);
      repeat (3) step();
      #1;
      chk1("t2_not_yet", flush, 1'b0);
      lsu_idle = 1'b1;
      step(); #1;
      chk1 ("t2_flush", flush,     1'b1);
      chk64("t2_epc",   epc_nxt,   64'h3004);
      chk64("t2_tgt",   flush_tgt, 64'h1300);
      step();

      // EDTM|EALIGN: EALIGN wins, ELSA from load/store address
      fire(64'h2100, 7'b0110000, 64'h8001, 1'b0);
      step(); #1;
      chk1 ("t3_elsa_we", elsa_we,   1'b1);
      chk64("t3_elsa",    elsa_nxt,  64'h8001);
      chk64("t3_tgt",     flush_tgt, 64'h1400);
      step();

      // ERET restores to current EPC
      msr_epc = 64'h4000;
      fire(64'h2200, 7'b0, 64'h0, 1'b1);
      step(); #1;
      chk1 ("t4_restore", psr_restore, 1'b1);
      chk1 ("t4_save",    psr_save,    1'b0);
      chk64("t4_tgt",     flush_tgt,   64'h4000);
      step();

      // ERET with EINSN: exception entry, no restore
      fire(64'h2200, 7'b0000100, 64'h0, 1'b1);
      step(); #1;
      chk1 ("t5_save",    psr_save,    1'b1);
      chk1 ("t5_restore", psr_restore, 1'b0);
      chk64("t5_tgt",     flush_tgt,   64'h1200);
      step();

      // IRQ masked: plain retire
      irq_async = 1'b1;
      fire(64'h5000, 7'b0, 64'h0, 1'b0);
      #1;
      chk1("t6_ready", cmt_ready, 1'b1);
      chk1("t6_busy",  busy,      1'b0);
      repeat (3) step();

      // IRQ enabled
      msr_psr_ire = 1'b1;
      fire(64'h5000, 7'b0, 64'h0, 1'b0);
      step(); #1;
      chk64("t7_epc", epc_nxt,   64'h5000);
      chk64("t7_tgt", flush_tgt, 64'h1700);
      chk1 ("t7_elsa_we", elsa_we, 1'b0);
      step();
      irq_async = 1'b0;

      // EITM|EDPF: EITM wins, ELSA = PC
      fire(64'h6000, 7'b1000001, 64'h7777, 1'b0);
      step(); #1;
      chk64("t8_elsa", elsa_nxt,  64'h6000);
      chk64("t8_tgt",  flush_tgt, 64'h1000);
      step();

      // Vector wraps modulo 2^64
      msr_evect = 64'hFFFF_FFFF_FFFF_FF00;
      fire(64'h6100, 7'b0000010, 64'h0, 1'b0);
      step(); #1;
      chk64("t9_wrap", flush_tgt, 64'h0);
      step();
      msr_evect = 64'h1000;

      // Reset mid-DRAIN discards the sequence
      lsu_idle = 1'b0;
      fire(64'h2000, 7'b0000100, 64'h0, 1'b0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk1("t10_ready", cmt_ready, 1'b1);
      chk1("t10_save",  psr_save,  1'b0);
      chk1("t10_flush", flush,     1'b0);
      lsu_idle = 1'b1;
      repeat (4) step();
      #1;
      chk1("t10_no_flush", flush, 1'b0);

      // Back-to-back: valid held high, next fire right after each flush
      cmt_valid = 1'b1;
      cmt_pc    = 64'h7000;
      cmt_exc   = 7'b1000000;
      cmt_lsa   = 64'hABC;
      repeat (8) step();
      cmt_exc   = 7'b0;
      repeat (3) step();
      cmt_valid = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
